// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register and a one-entry skid buffer.
// Optional macro FETCH_ALIGN_CHECK_EN: word-aligns branch targets and flags misaligned ones on AddrErr.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] ImemAddr,
    output logic        ImemReq,
    input  logic [31:0] ImemData,
    input  logic        ImemValid,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [31:0] IdPCPlus4,
    output logic        IdValid,
    output logic        AddrErr
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc4;
    logic        r_addr_err;

    logic        w_fire;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_misaligned;

    assign w_fire     = (r_state == S_FETCH) && ImemValid;
    assign w_pc_plus4 = r_pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_target     = {BranchTarget[31:2], 2'b00};
    assign w_misaligned = (BranchTarget[1:0] != 2'b00);
`else
    assign w_target     = BranchTarget;
    assign w_misaligned = 1'b0;
`endif

    // PC, IF/ID register, skid buffer and FETCH/HOLD state; a redirect overrides everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_instr      <= 32'h0000_0000;
            r_pc4        <= 32'h0000_0000;
            r_valid      <= 1'b0;
            r_skid_instr <= 32'h0000_0000;
            r_skid_pc4   <= 32'h0000_0000;
            r_addr_err   <= 1'b0;
        end else if (BranchTaken) begin
            r_state      <= S_FETCH;
            r_pc         <= w_target;
            r_instr      <= 32'h0000_0000;
            r_pc4        <= 32'h0000_0000;
            r_valid      <= 1'b0;
            r_skid_instr <= 32'h0000_0000;
            r_skid_pc4   <= 32'h0000_0000;
            r_addr_err   <= r_addr_err | w_misaligned;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fire) begin
                        r_pc <= w_pc_plus4;
                        // A stall only diverts into the skid when IF/ID holds a real instruction
                        if (!Stall || !r_valid) begin
                            r_instr <= ImemData;
                            r_pc4   <= w_pc_plus4;
                            r_valid <= 1'b1;
                        end else begin
                            r_skid_instr <= ImemData;
                            r_skid_pc4   <= w_pc_plus4;
                            r_state      <= S_HOLD;
                        end
                    end else if (!Stall) begin
                        r_instr <= 32'h0000_0000;
                        r_pc4   <= 32'h0000_0000;
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= r_valid;
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        r_instr      <= r_skid_instr;
                        r_pc4        <= r_skid_pc4;
                        r_valid      <= 1'b1;
                        r_skid_instr <= 32'h0000_0000;
                        r_skid_pc4   <= 32'h0000_0000;
                        r_state      <= S_FETCH;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign ImemAddr  = r_pc;
    assign ImemReq   = (r_state == S_FETCH);
    assign Instr     = r_instr;
    assign Op        = r_instr[31:26];
    assign IdPCPlus4 = r_pc4;
    assign IdValid   = r_valid;
    assign AddrErr   = r_addr_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns an address-derived word.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] ImemAddr;
    logic        ImemReq;
    logic [31:0] ImemData;
    logic        ImemValid;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic [31:0] IdPCPlus4;
    logic        IdValid;
    logic        AddrErr;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .ImemAddr(ImemAddr), .ImemReq(ImemReq),
        .ImemData(ImemData), .ImemValid(ImemValid), .Instr(Instr), .Op(Op),
        .IdPCPlus4(IdPCPlus4), .IdValid(IdValid), .AddrErr(AddrErr)
    );

    function automatic logic [31:0] mk_word(input logic [31:0] a);
        return {a[7:2] + 6'd1, 10'h155, a[15:0]};
    endfunction

    assign ImemData = mk_word(ImemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] addr);
        logic [31:0] w;
        w = mk_word(addr);
        check_eq({tag, "_instr"}, Instr, w);
        check_eq({tag, "_op"}, {26'd0, Op}, {26'd0, w[31:26]});
        check_eq({tag, "_pc4"}, IdPCPlus4, addr + 32'd4);
        check_eq({tag, "_valid"}, {31'd0, IdValid}, 32'd1);
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_instr"}, Instr, 32'd0);
        check_eq({tag, "_pc4"}, IdPCPlus4, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, IdValid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0;
        BranchTarget = 32'd0; ImemValid = 1'b1;
        #12;
        // reset state
        check_eq("rst_addr", ImemAddr, 32'd0);
        check_eq("rst_req", {31'd0, ImemReq}, 32'd1);
        check_bubble("rst");
        check_eq("rst_op", {26'd0, Op}, 32'd0);
        check_eq("rst_err", {31'd0, AddrErr}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("first_addr", ImemAddr, 32'd0);
        check_eq("first_req", {31'd0, ImemReq}, 32'd1);

        // streaming
        step(); check_id("s0", 32'h0);
        step(); check_id("s4", 32'h4);
        step(); check_id("s8", 32'h8);
        check_eq("s8_addr", ImemAddr, 32'hC);

        // three-cycle stall: word @C goes to skid
        Stall = 1'b1;
        step(); check_id("st1", 32'h8);
        check_eq("st1_req", {31'd0, ImemReq}, 32'd0);
        check_eq("st1_addr", ImemAddr, 32'h10);
        step(); check_id("st2", 32'h8);
        check_eq("st2_req", {31'd0, ImemReq}, 32'd0);
        step(); check_id("st3", 32'h8);
        Stall = 1'b0;
        step(); check_id("skid", 32'hC);
        check_eq("skid_req", {31'd0, ImemReq}, 32'd1);
        check_eq("skid_addr", ImemAddr, 32'h10);
        step(); check_id("after", 32'h10);

        // branch while in HOLD
        Stall = 1'b1;
        step(); check_eq("hold_req", {31'd0, ImemReq}, 32'd0);
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        step();
        check_eq("br_addr", ImemAddr, 32'h40);
        check_eq("br_req", {31'd0, ImemReq}, 32'd1);
        check_bubble("br");
        BranchTaken = 1'b0; Stall = 1'b0;
        step(); check_id("br40", 32'h40);

        // ImemValid toggling
        ImemValid = 1'b0;
        step(); check_bubble("nv1"); check_eq("nv1_addr", ImemAddr, 32'h44);
        ImemValid = 1'b1;
        step(); check_id("v44", 32'h44);
        ImemValid = 1'b0;
        step(); check_bubble("nv2"); check_eq("nv2_addr", ImemAddr, 32'h48);
        ImemValid = 1'b1;
        step(); check_id("v48", 32'h48);
        ImemValid = 1'b0; Stall = 1'b1;
        step(); check_id("nvst", 32'h48);
        Stall = 1'b0;
        step(); check_bubble("nv3");
        // stall never holds a bubble
        ImemValid = 1'b1; Stall = 1'b1;
        step(); check_id("stbub", 32'h4C);
        check_eq("stbub_req", {31'd0, ImemReq}, 32'd1);

        // asynchronous reset during a stall
        step(); check_eq("pre_rst_req", {31'd0, ImemReq}, 32'd0);
        #2; rst = 1'b1; #1;
        check_eq("arst_addr", ImemAddr, 32'd0);
        check_eq("arst_req", {31'd0, ImemReq}, 32'd1);
        check_bubble("arst");
        #1; rst = 1'b0; Stall = 1'b0;
        step(); check_id("restart", 32'h0);

        // misaligned branch target
        BranchTaken = 1'b1; BranchTarget = 32'h43;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("mis_addr", ImemAddr, 32'h40);
        check_eq("mis_err", {31'd0, AddrErr}, 32'd1);
        BranchTaken = 1'b0;
        step(); check_eq("mis_sticky", {31'd0, AddrErr}, 32'd1);
`else
        check_eq("mis_addr", ImemAddr, 32'h43);
        check_eq("mis_err", {31'd0, AddrErr}, 32'd0);
        BranchTaken = 1'b0;
        step(); check_eq("mis_sticky", {31'd0, AddrErr}, 32'd0);
`endif

        // PC+4 wrap
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        step(); check_eq("wrap_br", ImemAddr, 32'hFFFF_FFFC);
        BranchTaken = 1'b0;
        step(); check_id("wrap", 32'hFFFF_FFFC);
        check_eq("wrap_addr", ImemAddr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("wrap_err", {31'd0, AddrErr}, 32'd1);
`endif
        #2; rst = 1'b1; #1;
        check_eq("rst2_err", {31'd0, AddrErr}, 32'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
